// File: rtl/wdog_multi.sv
// wdog_multi: NUM_CH watchdog channels sharing one prescaler, each with a warn then bite timeout.
// Define WDOG_LOCK_EN to add the configuration LOCK register at address 0xC.
module wdog_multi #(
   parameter int          NUM_CH     = 2,
   parameter int          CNT_W      = 16,
   parameter int          PRESCALE_W = 8,
   parameter logic [15:0] KICK_KEY   = 16'hA5A5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        addr,
   input  logic [31:0]       wdata,
   input  logic              write,
   input  logic              read,
   output logic [31:0]       rdata,
   output logic              irq,
   output logic [NUM_CH-1:0] wdog_rst
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WARN, ST_BITE} state_t;

   localparam logic [3:0] A_CTRL     = 4'h0;
   localparam logic [3:0] A_PRESCALE = 4'h1;
   localparam logic [3:0] A_STATUS   = 4'h2;
   localparam logic [3:0] A_KICK     = 4'h3;
   localparam int         A_LOAD     = 4;
   localparam int         A_WARN     = 8;

   logic [NUM_CH-1:0]     ctrl_q, ctrl_d;
   logic [PRESCALE_W-1:0] prescale_q, presc_cnt_q;
   logic [CNT_W-1:0]      load_q [NUM_CH];
   logic [CNT_W-1:0]      warn_q [NUM_CH];
   logic [CNT_W-1:0]      cnt_q  [NUM_CH];
   logic [CNT_W-1:0]      cnt_d  [NUM_CH];
   state_t                state_q [NUM_CH];
   state_t                state_d [NUM_CH];
   logic [NUM_CH-1:0]     warn_flag_q, warn_flag_d, bite_flag_q, bite_flag_d;
   logic [31:0]           rd_val;
   logic                  cfg_wr, tick, kick_wr, key_ok, w1c;
   logic                  unused_bits;

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

`ifdef WDOG_LOCK_EN
   localparam logic [3:0]  A_LOCK   = 4'hC;
   localparam logic [31:0] LOCK_KEY = 32'h1ACC_E55D;
   logic lock_q;

   // Lock is sticky: only rst_n releases it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          lock_q <= 1'b0;
      else if (write && addr == A_LOCK && wdata == LOCK_KEY) lock_q <= 1'b1;
   end
   assign cfg_wr = write && !lock_q;
`else
   assign cfg_wr = write;
`endif

   assign unused_bits = ^wdata;
   assign kick_wr = write && (addr == A_KICK);
   assign key_ok  = (wdata[15:0] == KICK_KEY);
   assign w1c     = write && (addr == A_STATUS);
   assign tick    = (|ctrl_q) && (presc_cnt_q == prescale_q);
   assign irq     = |warn_flag_q;
   assign wdog_rst = bite_flag_q;

   always_comb begin
      ctrl_d = ctrl_q;
      if (cfg_wr && addr == A_CTRL) ctrl_d = wdata[NUM_CH-1:0];
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c]     = state_q[c];
         cnt_d[c]       = cnt_q[c];
         warn_flag_d[c] = warn_flag_q[c];
         bite_flag_d[c] = bite_flag_q[c];
         if (w1c && wdata[c]) warn_flag_d[c] = 1'b0;
         if (!ctrl_d[c]) begin
            state_d[c]     = ST_IDLE;
            cnt_d[c]       = '0;
            warn_flag_d[c] = 1'b0;
            bite_flag_d[c] = 1'b0;
         end else begin
            case (state_q[c])
               ST_IDLE: begin
                  state_d[c] = ST_RUN;
                  cnt_d[c]   = load_q[c];
               end
               ST_RUN, ST_WARN: begin
                  if (kick_wr && wdata[16+c]) begin
                     if (key_ok) begin
                        state_d[c] = ST_RUN;
                        cnt_d[c]   = load_q[c];
                     end else begin
                        state_d[c]     = ST_BITE;
                        bite_flag_d[c] = 1'b1;
                     end
                  end else if (tick) begin
                     cnt_d[c] = sat_dec(cnt_q[c]);
                     // A count that lands on zero bites even if the warn stage was skipped.
                     if (sat_dec(cnt_q[c]) == '0) begin
                        state_d[c]     = ST_BITE;
                        bite_flag_d[c] = 1'b1;
                     end else if (state_q[c] == ST_RUN && sat_dec(cnt_q[c]) <= warn_q[c]) begin
                        state_d[c]     = ST_WARN;
                        warn_flag_d[c] = 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warn_flag_q <= '0;
         bite_flag_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= ST_IDLE;
            cnt_q[c]   <= '0;
         end
      end else begin
         warn_flag_q <= warn_flag_d;
         bite_flag_q <= bite_flag_d;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
      end
   end

   // NOTE: the LOAD/WARN arrays are software-visible registers, so they are reset like any other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            load_q[c] <= '0;
            warn_q[c] <= '0;
         end
      end else begin
         ctrl_q <= ctrl_d;
         if (cfg_wr && addr == A_PRESCALE) prescale_q <= wdata[PRESCALE_W-1:0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_wr && addr == 4'(A_LOAD + c)) load_q[c] <= wdata[CNT_W-1:0];
            if (cfg_wr && addr == 4'(A_WARN + c)) warn_q[c] <= wdata[CNT_W-1:0];
         end
      end
   end

   // Prescaler idles at 0 while every channel is off, so the first tick is PRESCALE+1 CLKs in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          presc_cnt_q <= '0;
      else if ((cfg_wr && addr == A_PRESCALE) || !(|ctrl_q)) presc_cnt_q <= '0;
      else if (tick)                                       presc_cnt_q <= '0;
      else                                                 presc_cnt_q <= presc_cnt_q + 1'b1;
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         A_CTRL:     rd_val[NUM_CH-1:0]     = ctrl_q;
         A_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale_q;
         A_STATUS: begin
            rd_val[NUM_CH-1:0]   = warn_flag_q;
            rd_val[4 +: NUM_CH]  = bite_flag_q;
         end
`ifdef WDOG_LOCK_EN
         A_LOCK:     rd_val[0] = lock_q;
`endif
         default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
         if (addr == 4'(A_LOAD + c)) rd_val[CNT_W-1:0] = load_q[c];
         if (addr == 4'(A_WARN + c)) rd_val[CNT_W-1:0] = warn_q[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata <= '0;
      else if (read) rdata <= rd_val;
   end

endmodule

// File: tb/tb_wdog_multi.sv
// tb_wdog_multi: directed scenarios plus randomized bus traffic checked against a behavioural model.
module tb_wdog_multi;

   localparam int NUM_CH = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        addr;
   logic [31:0]       wdata;
   logic              write, read;
   logic [31:0]       rdata;
   logic              irq;
   logic [NUM_CH-1:0] wdog_rst;

   int n_vec = 0;
   int n_err = 0;

   wdog_multi #(
      .NUM_CH(NUM_CH), .CNT_W(16), .PRESCALE_W(8), .KICK_KEY(16'hA5A5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .write(write),
      .read(read), .rdata(rdata), .irq(irq), .wdog_rst(wdog_rst)
   );

   always #5 clk = ~clk;

   // Behavioural model: remaining time per channel plus "counting", "past warning" and "bitten" flags.
   bit [NUM_CH-1:0] m_ctrl, m_active, m_late, m_bit, m_wflag;
   int              m_load [NUM_CH];
   int              m_warn [NUM_CH];
   int              m_cnt  [NUM_CH];
   int              m_presc, m_since;
   bit              m_lock;
   logic [31:0]     m_rdata;

   function automatic void model_reset();
      m_ctrl = '0; m_active = '0; m_late = '0; m_bit = '0; m_wflag = '0;
      m_presc = 0; m_since = 0; m_lock = 1'b0; m_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_load[c] = 0; m_warn[c] = 0; m_cnt[c] = 0;
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      logic [31:0] v;
      v = '0;
      if (a == 4'h0) v[NUM_CH-1:0] = m_ctrl;
      if (a == 4'h1) v = 32'(m_presc);
      if (a == 4'h2) begin
         v[NUM_CH-1:0]  = m_wflag;
         v[4 +: NUM_CH] = m_bit;
      end
`ifdef WDOG_LOCK_EN
      if (a == 4'hC) v[0] = m_lock;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         if (a == 4'(4 + c)) v = 32'(m_load[c]);
         if (a == 4'(8 + c)) v = 32'(m_warn[c]);
      end
      return v;
   endfunction

   function automatic void model_step(input logic [3:0] a, input logic [31:0] d,
                                      input logic w, input logic r);
      bit              cfg, tick;
      bit [NUM_CH-1:0] nctrl;
      logic [31:0]     rv;
      cfg   = w && !m_lock;
      rv    = model_read(a);
      tick  = (m_ctrl != 0) && (m_since == m_presc);
      nctrl = (cfg && a == 4'h0) ? d[NUM_CH-1:0] : m_ctrl;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w && a == 4'h2 && d[c]) m_wflag[c] = 1'b0;
         if (!nctrl[c]) begin
            m_active[c] = 0; m_late[c] = 0; m_bit[c] = 0; m_wflag[c] = 0; m_cnt[c] = 0;
         end else if (m_bit[c]) begin
            m_bit[c] = 1'b1;
         end else if (!m_active[c]) begin
            m_active[c] = 1; m_late[c] = 0; m_cnt[c] = m_load[c];
         end else if (w && a == 4'h3 && d[16+c]) begin
            if (d[15:0] == 16'hA5A5) begin
               m_cnt[c] = m_load[c]; m_late[c] = 0;
            end else begin
               m_active[c] = 0; m_bit[c] = 1;
            end
         end else if (tick) begin
            if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
            if (m_cnt[c] == 0) begin
               m_active[c] = 0; m_bit[c] = 1;
            end else if (!m_late[c] && m_cnt[c] <= m_warn[c]) begin
               m_late[c] = 1; m_wflag[c] = 1;
            end
         end
      end
      if ((cfg && a == 4'h1) || m_ctrl == 0 || tick) m_since = 0;
      else                                         m_since = m_since + 1;
      if (cfg) begin
         if (a == 4'h0) m_ctrl = nctrl;
         if (a == 4'h1) m_presc = int'(d[7:0]);
         for (int c = 0; c < NUM_CH; c++) begin
            if (a == 4'(4 + c)) m_load[c] = int'(d[15:0]);
            if (a == 4'(8 + c)) m_warn[c] = int'(d[15:0]);
         end
      end
`ifdef WDOG_LOCK_EN
      if (w && a == 4'hC && d == 32'h1ACC_E55D) m_lock = 1'b1;
`endif
      if (r) m_rdata = rv;
   endfunction

   task automatic cycle(input logic [3:0] a, input logic [31:0] d, input logic w, input logic r);
      addr = a; wdata = d; write = w; read = r;
      @(posedge clk);
      model_step(a, d, w, r);
      #1;
      addr = '0; wdata = '0; write = 1'b0; read = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(4'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      addr = '0; wdata = '0; write = 1'b0; read = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_vec++;
      if ({rdata, irq, wdog_rst} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %h/%b/%b want 0", rdata, irq, wdog_rst);
      end
      for (int a = 0; a < 16; a++) begin
         cycle(4'(a), 32'h0, 1'b0, 1'b1);
         n_vec++;
         if (rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_reg%0d: got %h want 0", a, rdata);
         end
      end
   endtask

   task automatic test_timeout();
      int irq_at, bite_at;
      irq_at = -1; bite_at = -1;
      cycle(4'h1, 32'd0, 1'b1, 1'b0);
      cycle(4'h4, 32'd10, 1'b1, 1'b0);
      cycle(4'h8, 32'd3, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         idle(1);
         if (irq && irq_at < 0) irq_at = i;
         if (wdog_rst[0] && bite_at < 0) bite_at = i;
         n_vec++;
         if ({irq, wdog_rst} !== {|m_wflag, m_bit}) begin
            n_err++; $display("FAIL timeout_cyc%0d: got %b/%b want %b/%b", i, irq, wdog_rst, |m_wflag, m_bit);
         end
      end
      n_vec++;
      if (irq_at != 7) begin n_err++; $display("FAIL timeout_irq_tick: got %0d want 7", irq_at); end
      n_vec++;
      if (bite_at != 10) begin n_err++; $display("FAIL timeout_bite_tick: got %0d want 10", bite_at); end
      cycle(4'h2, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h11) begin n_err++; $display("FAIL timeout_status: got %h want 11", rdata); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      n_vec++;
      if ({irq, wdog_rst} !== 3'b000) begin
         n_err++; $display("FAIL timeout_disable: got %b/%b want 0/00", irq, wdog_rst);
      end
   endtask

   task automatic test_kick();
      int bad;
      bad = 0;
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) begin
         if (i % 5 == 0) cycle(4'h3, 32'h0001_A5A5, 1'b1, 1'b0);
         else            idle(1);
         if (irq !== 1'b0 || wdog_rst !== 2'b00) bad++;
      end
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL kick_keepalive: got %0d bad cycles want 0", bad); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_bad_key();
      cycle(4'h5, 32'd50, 1'b1, 1'b0);
      cycle(4'h9, 32'd5, 1'b1, 1'b0);
      cycle(4'h0, 32'd2, 1'b1, 1'b0);
      idle(3);
      cycle(4'h3, 32'h0002_1234, 1'b1, 1'b0);
      n_vec++;
      if (wdog_rst !== 2'b10) begin n_err++; $display("FAIL badkey_bite: got %b want 10", wdog_rst); end
      cycle(4'h2, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h20) begin n_err++; $display("FAIL badkey_status: got %h want 20", rdata); end
      cycle(4'h3, 32'h0002_A5A5, 1'b1, 1'b0);
      idle(2);
      n_vec++;
      if ({irq, wdog_rst} !== 3'b010) begin
         n_err++; $display("FAIL bite_hold: got %b/%b want 0/10", irq, wdog_rst);
      end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      n_vec++;
      if (wdog_rst !== 2'b00) begin n_err++; $display("FAIL bite_release: got %b want 00", wdog_rst); end
   endtask

   task automatic test_kick_tick();
      cycle(4'h4, 32'd4, 1'b1, 1'b0);
      cycle(4'h8, 32'd0, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      idle(3);
      cycle(4'h3, 32'h0001_A5A5, 1'b1, 1'b0);
      n_vec++;
      if (wdog_rst !== 2'b00) begin n_err++; $display("FAIL kicktick_nobite: got %b want 00", wdog_rst); end
      idle(3);
      n_vec++;
      if (wdog_rst !== 2'b00) begin n_err++; $display("FAIL kicktick_reload: got %b want 00", wdog_rst); end
      idle(1);
      n_vec++;
      if (wdog_rst !== 2'b01) begin n_err++; $display("FAIL kicktick_later_bite: got %b want 01", wdog_rst); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_boundaries();
      cycle(4'h4, 32'd0, 1'b1, 1'b0);
      cycle(4'h8, 32'd0, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      n_vec++;
      if (wdog_rst !== 2'b00) begin n_err++; $display("FAIL load0_enable: got %b want 00", wdog_rst); end
      idle(1);
      n_vec++;
      if (wdog_rst !== 2'b01) begin n_err++; $display("FAIL load0_first_tick: got %b want 01", wdog_rst); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      cycle(4'h4, 32'd5, 1'b1, 1'b0);
      cycle(4'h8, 32'd9, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      idle(1);
      n_vec++;
      if ({irq, wdog_rst} !== 3'b100) begin
         n_err++; $display("FAIL warn_ge_load: got %b/%b want 1/00", irq, wdog_rst);
      end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      cycle(4'h8, 32'd3, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      idle(1);
      cycle(4'h2, 32'h1, 1'b1, 1'b0);
      n_vec++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL w1c_collision: got %b want 1", irq); end
      cycle(4'h2, 32'h1, 1'b1, 1'b0);
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got %b want 0", irq); end
      idle(2);
      n_vec++;
      if (wdog_rst !== 2'b01) begin n_err++; $display("FAIL saturate_bite: got %b want 01", wdog_rst); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      cycle(4'h1, 32'd2, 1'b1, 1'b0);
      cycle(4'h4, 32'd2, 1'b1, 1'b0);
      cycle(4'h8, 32'd0, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      idle(5);
      n_vec++;
      if (wdog_rst !== 2'b00) begin n_err++; $display("FAIL prescale_early: got %b want 00", wdog_rst); end
      idle(1);
      n_vec++;
      if (wdog_rst !== 2'b01) begin n_err++; $display("FAIL prescale_bite: got %b want 01", wdog_rst); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      cycle(4'h1, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      cycle(4'h4, 32'd10, 1'b1, 1'b0);
      cycle(4'h8, 32'd3, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      idle(8);
      cycle(4'h4, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if ({rdata, irq} !== {32'd10, 1'b1}) begin
         n_err++; $display("FAIL midreset_pre: got %h/%b want 0000000a/1", rdata, irq);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({rdata, irq, wdog_rst} !== '0) begin
         n_err++; $display("FAIL midreset_async: got %h/%b/%b want 0", rdata, irq, wdog_rst);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         cycle(4'(a), 32'h0, 1'b0, 1'b1);
         n_vec++;
         if (rdata !== 32'h0) begin n_err++; $display("FAIL midreset_reg%0d: got %h want 0", a, rdata); end
      end
   endtask

`ifdef WDOG_LOCK_EN
   task automatic test_lock();
      apply_reset();
      cycle(4'hC, 32'h1234_5678, 1'b1, 1'b0);
      cycle(4'hC, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL lock_wrong_value: got %h want 0", rdata); end
      cycle(4'h4, 32'd1000, 1'b1, 1'b0);
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      cycle(4'hC, 32'h1ACC_E55D, 1'b1, 1'b0);
      cycle(4'hC, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h1) begin n_err++; $display("FAIL lock_set: got %h want 1", rdata); end
      cycle(4'h0, 32'h0, 1'b1, 1'b0);
      cycle(4'h4, 32'd5, 1'b1, 1'b0);
      cycle(4'h0, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h1) begin n_err++; $display("FAIL lock_ctrl: got %h want 1", rdata); end
      cycle(4'h4, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'd1000) begin n_err++; $display("FAIL lock_load: got %h want 3e8", rdata); end
      apply_reset();
      cycle(4'h0, 32'd1, 1'b1, 1'b0);
      cycle(4'h0, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h1) begin n_err++; $display("FAIL unlock_ctrl: got %h want 1", rdata); end
      cycle(4'hC, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL unlock_read: got %h want 0", rdata); end
   endtask
`endif

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         int          op;
         logic [3:0]  a;
         logic [31:0] d;
         logic        w, r;
         op = int'($urandom_range(0, 99));
         a = '0; d = '0; w = 1'b0; r = ($urandom_range(0, 2) == 0);
         if (op < 45) begin
            a = 4'($urandom_range(0, 15));
         end else if (op < 65) begin
            w = 1'b1; a = 4'h3; d = {12'h0, 4'($urandom_range(1, 3)), 16'hA5A5};
         end else if (op < 67) begin
            w = 1'b1; a = 4'h3; d = {12'h0, 4'($urandom_range(1, 15)), 16'($urandom)};
         end else if (op < 72) begin
            w = 1'b1; a = 4'h0; d = 32'($urandom_range(0, 3));
         end else if (op < 80) begin
            w = 1'b1; a = 4'($urandom_range(4, 7)); d = 32'($urandom_range(0, 15));
         end else if (op < 88) begin
            w = 1'b1; a = 4'($urandom_range(8, 11)); d = 32'($urandom_range(0, 10));
         end else if (op < 90) begin
            w = 1'b1; a = 4'h1; d = 32'($urandom_range(0, 2));
         end else if (op < 96) begin
            w = 1'b1; a = 4'h2; d = $urandom;
         end else begin
            w = 1'b1; a = 4'($urandom_range(0, 15)); d = 32'($urandom_range(0, 20));
         end
         cycle(a, d, w, r);
         n_vec++;
         if ({rdata, irq, wdog_rst} !== {m_rdata, |m_wflag, m_bit}) begin
            n_err++;
            $display("FAIL random_cyc%0d: got %h/%b/%b want %h/%b/%b",
                     i, rdata, irq, wdog_rst, m_rdata, |m_wflag, m_bit);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_kick();
      test_bad_key();
      test_kick_tick();
      test_boundaries();
      test_reset_mid();
`ifdef WDOG_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
